m_axi_seq: RTL and testbench

Test sequencer for the AXI4 master traffic generator: it runs a programmable number of write/read-verify passes back to back and reports aggregate status. It sits between the host control/status registers and the traffic generator's `req`/`ack`/`err` handshake.
- Issues each pass as a one-cycle `req` pulse.
- Waits for the pass to complete, with an optional watchdog timeout.
- Counts passes and failing passes.
- Inserts a fixed idle gap between passes.

---
 rtl/m_axi_seq_pkg.sv | 20 ++
 rtl/m_axi_seq_timer.sv | 34 +++
 rtl/m_axi_seq.sv | 180 ++++++++++++++++++
 tb/tb_m_axi_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_axi_seq_pkg.sv
// Shared types and defaults for the AXI traffic test sequencer.
package m_axi_seq_pkg;

  localparam int DEF_PASS_WIDTH = 16;
  localparam int DEF_TO_WIDTH   = 24;
  localparam int DEF_GAP_CYCLES = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/m_axi_seq_timer.sv
// Loadable down-counter with an expire flag; reused by the pass watchdog and the inter-pass gap.
module m_axi_seq_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             xrst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/m_axi_seq.sv
// Runs a programmed number of traffic-generator passes back to back and reports aggregate status.
//
//   state  | meaning
//   S_IDLE | wait for start
//   S_REQ  | req pulse, arm watchdog
//   S_WAIT | wait for ack or watchdog expiry
//   S_GAP  | fixed idle gap before next pass
//   S_DONE | one-cycle wrap-up, done set on exit
module m_axi_seq
  import m_axi_seq_pkg::*;
#(
  parameter int PASS_WIDTH = DEF_PASS_WIDTH,
  parameter int TO_WIDTH   = DEF_TO_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                  clk,
  input  logic                  xrst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [PASS_WIDTH-1:0] num_pass,
  input  logic [TO_WIDTH-1:0]   timeout,
  output logic                  req,
  input  logic                  ack,
  input  logic                  err,
  output logic                  busy,
  output logic                  done,
  output logic [PASS_WIDTH-1:0] pass_cnt,
  output logic [PASS_WIDTH-1:0] err_cnt,
  output logic [PASS_WIDTH-1:0] first_fail,
  output logic                  to_flag,
  output logic                  abort_flag
);

  localparam int TW = max_int(TO_WIDTH, 8);

  state_e                state_q, state_d;
  logic [PASS_WIDTH-1:0] num_pass_q, num_pass_d;
  logic [TO_WIDTH-1:0]   timeout_q, timeout_d;
  logic [PASS_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
  logic [PASS_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [PASS_WIDTH-1:0] first_fail_q, first_fail_d;
  logic                  to_flag_q, to_flag_d;
  logic                  abort_flag_q, abort_flag_d;
  logic                  done_q, done_d;
  logic                  req_q, req_d;
  logic                  busy_q, busy_d;

  logic                  tmr_load, tmr_dec, tmr_expired;
  logic [TW-1:0]         tmr_load_val;

  m_axi_seq_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .xrst     (xrst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    num_pass_d   = num_pass_q;
    timeout_d    = timeout_q;
    pass_cnt_d   = pass_cnt_q;
    err_cnt_d    = err_cnt_q;
    first_fail_d = first_fail_q;
    to_flag_d    = to_flag_q;
    abort_flag_d = abort_flag_q;
    done_d       = done_q;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    tmr_load_val = TW'(GAP_CYCLES - 1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_pass_d   = num_pass;
          timeout_d    = timeout;
          pass_cnt_d   = '0;
          err_cnt_d    = '0;
          first_fail_d = '1;
          to_flag_d    = 1'b0;
          abort_flag_d = 1'b0;
          done_d       = 1'b0;
          state_d      = (num_pass == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (abort) begin
          abort_flag_d = 1'b1;
          state_d      = S_DONE;
        end else begin
          // Timer counts down to zero on the timeout-th waiting cycle.
          tmr_load     = 1'b1;
          tmr_load_val = TW'(timeout_q - 1'b1);
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          abort_flag_d = 1'b1;
          state_d      = S_DONE;
        end else if (ack) begin
          pass_cnt_d = pass_cnt_q + 1'b1;
          if (err) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (first_fail_q == '1) first_fail_d = pass_cnt_q;
          end
          if (pass_cnt_d == num_pass_q) begin
            state_d = S_DONE;
          end else begin
            tmr_load = 1'b1;
            state_d  = S_GAP;
          end
        end else if ((timeout_q != '0) && tmr_expired) begin
          to_flag_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          abort_flag_d = 1'b1;
          state_d      = S_DONE;
        end else if (tmr_expired) begin
          state_d = S_REQ;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_d  = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q      <= S_IDLE;
      num_pass_q   <= '0;
      timeout_q    <= '0;
      pass_cnt_q   <= '0;
      err_cnt_q    <= '0;
      first_fail_q <= '1;
      to_flag_q    <= 1'b0;
      abort_flag_q <= 1'b0;
      done_q       <= 1'b0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_pass_q   <= num_pass_d;
      timeout_q    <= timeout_d;
      pass_cnt_q   <= pass_cnt_d;
      err_cnt_q    <= err_cnt_d;
      first_fail_q <= first_fail_d;
      to_flag_q    <= to_flag_d;
      abort_flag_q <= abort_flag_d;
      done_q       <= done_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
    end
  end

  assign req        = req_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass_cnt   = pass_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign first_fail = first_fail_q;
  assign to_flag    = to_flag_q;
  assign abort_flag = abort_flag_q;

endmodule

// File: tb/tb_m_axi_seq.sv
// Bench for m_axi_seq: a per-pass latency/error generator, a cycle-timing model, vector table and corner sequences.
module tb_m_axi_seq;

  localparam int PW  = 16;
  localparam int TWD = 24;
  localparam int GAP = 4;
  localparam int NO_FAIL = 16'hFFFF;

  logic clk = 1'b0;
  logic xrst, start, abort, ack, err;
  logic req, busy, done, to_flag, abort_flag;
  logic [PW-1:0]  num_pass, pass_cnt, err_cnt, first_fail;
  logic [TWD-1:0] timeout;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // Generator programming: latency 0 means the pass never completes.
  int gen_lat [16];
  bit gen_errv[16];
  int gen_idx = 0;
  int gen_left = 0;
  bit gen_err_now = 1'b0;

  int req_log[$];
  int exp_req[$];
  int exp_done;
  int m_pass, m_err, m_ff;
  bit m_to;

  typedef struct {
    int n; int t; int lat; int err_mask;
    int e_pass; int e_err; int e_ff; bit e_to;
  } vec_t;

  m_axi_seq #(.PASS_WIDTH(PW), .TO_WIDTH(TWD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .xrst(xrst), .start(start), .abort(abort),
    .num_pass(num_pass), .timeout(timeout), .req(req), .ack(ack), .err(err),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
    .first_fail(first_fail), .to_flag(to_flag), .abort_flag(abort_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    ack = 1'b0;
    err = 1'b0;
    forever begin
      @(negedge clk);
      if (req === 1'b1) begin
        ack = 1'b0;
        err = 1'b0;
        gen_left    = (gen_idx < 16) ? gen_lat[gen_idx] : 1;
        gen_err_now = (gen_idx < 16) ? gen_errv[gen_idx] : 1'b0;
        gen_idx++;
      end else if (gen_left > 0) begin
        gen_left--;
        if (gen_left == 0) begin
          ack = 1'b1;
          err = gen_err_now;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (req === 1'b1) req_log.push_back(cyc);
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected req cycles, done cycle and final status from per-pass latencies.
  task automatic model(input int n, input int t, input int sc);
    int r;
    exp_req.delete();
    m_pass = 0; m_err = 0; m_ff = NO_FAIL; m_to = 1'b0;
    r = sc + 1;
    exp_done = sc + 2;
    for (int i = 0; i < n; i++) begin
      exp_req.push_back(r);
      if (gen_lat[i] == 0 || (t != 0 && gen_lat[i] > t)) begin
        m_to = 1'b1;
        exp_done = r + t + 2;
        break;
      end
      m_pass++;
      if (gen_errv[i]) begin
        m_err++;
        if (m_ff == NO_FAIL) m_ff = i;
      end
      if (m_pass == n) begin
        exp_done = r + gen_lat[i] + 2;
        break;
      end
      r = r + gen_lat[i] + 1 + GAP;
    end
  endtask

  task automatic run(input int n, input int t, input string tag,
                     input int e_pass, input int e_err, input int e_ff, input bit e_to);
    int sc, dc;
    @(negedge clk);
    req_log.delete();
    gen_idx = 0;
    num_pass = PW'(n);
    timeout = TWD'(t);
    start = 1'b1;
    sc = cyc;
    model(n, t, sc);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("%s/done_clr", tag), done, 0);
    dc = -1;
    for (int k = 0; k < 3000; k++) begin
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("%s/done_cycle", tag), dc, exp_done);
    check($sformatf("%s/req_count", tag), req_log.size(), exp_req.size());
    for (int i = 0; i < exp_req.size() && i < req_log.size(); i++)
      check($sformatf("%s/req%0d_cycle", tag, i), req_log[i], exp_req[i]);
    check($sformatf("%s/pass_cnt", tag), pass_cnt, e_pass);
    check($sformatf("%s/err_cnt", tag), err_cnt, e_err);
    check($sformatf("%s/first_fail", tag), first_fail, e_ff);
    check($sformatf("%s/to_flag", tag), to_flag, e_to);
    check($sformatf("%s/abort_flag", tag), abort_flag, 0);
    check($sformatf("%s/busy", tag), busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check($sformatf("%s/req", tag), req, 0);
    check($sformatf("%s/busy", tag), busy, 0);
    check($sformatf("%s/done", tag), done, 0);
    check($sformatf("%s/pass_cnt", tag), pass_cnt, 0);
    check($sformatf("%s/err_cnt", tag), err_cnt, 0);
    check($sformatf("%s/first_fail", tag), first_fail, NO_FAIL);
    check($sformatf("%s/to_flag", tag), to_flag, 0);
    check($sformatf("%s/abort_flag", tag), abort_flag, 0);
  endtask

  task automatic set_gen(input int lat, input int mask);
    for (int i = 0; i < 16; i++) begin
      gen_lat[i]  = lat;
      gen_errv[i] = mask[i];
    end
  endtask

  initial begin
    vec_t vecs[$];
    int sc, k;

    xrst = 1'b0; start = 1'b0; abort = 1'b0; num_pass = '0; timeout = '0;
    set_gen(3, 0);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    xrst = 1'b1;

    vecs.push_back('{n:3, t:0,   lat:5, err_mask:'b0000, e_pass:3, e_err:0, e_ff:NO_FAIL, e_to:0});
    vecs.push_back('{n:4, t:0,   lat:3, err_mask:'b0100, e_pass:4, e_err:1, e_ff:2,       e_to:0});
    vecs.push_back('{n:2, t:100, lat:0, err_mask:'b0000, e_pass:0, e_err:0, e_ff:NO_FAIL, e_to:1});
    vecs.push_back('{n:1, t:5,   lat:5, err_mask:'b0000, e_pass:1, e_err:0, e_ff:NO_FAIL, e_to:0});
    vecs.push_back('{n:1, t:5,   lat:6, err_mask:'b0001, e_pass:0, e_err:0, e_ff:NO_FAIL, e_to:1});
    vecs.push_back('{n:3, t:0,   lat:1, err_mask:'b0111, e_pass:3, e_err:3, e_ff:0,       e_to:0});
    vecs.push_back('{n:2, t:3,   lat:2, err_mask:'b0010, e_pass:2, e_err:1, e_ff:1,       e_to:0});
    vecs.push_back('{n:1, t:1,   lat:1, err_mask:'b0000, e_pass:1, e_err:0, e_ff:NO_FAIL, e_to:0});
    for (int v = 0; v < vecs.size(); v++) begin
      set_gen(vecs[v].lat, vecs[v].err_mask);
      run(vecs[v].n, vecs[v].t, $sformatf("vec%0d", v),
          vecs[v].e_pass, vecs[v].e_err, vecs[v].e_ff, vecs[v].e_to);
    end

    // Abort during the second of five passes, then rerun.
    set_gen(6, 0);
    @(negedge clk);
    req_log.delete(); gen_idx = 0;
    num_pass = 5; timeout = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (req_log.size() < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("abort/second_req_seen", req_log.size(), 2);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort/abort_flag", abort_flag, 1);
    check("abort/pass_cnt", pass_cnt, 1);
    check("abort/to_flag", to_flag, 0);
    repeat (30) @(negedge clk);
    check("abort/no_more_req", req_log.size(), 2);
    check("abort/done", done, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle/busy", busy, 0);
    check("abort_idle/pass_cnt", pass_cnt, 1);
    set_gen(3, 0);
    run(2, 0, "rerun", 2, 0, NO_FAIL, 0);

    // Zero passes; a start pulsed while busy is ignored.
    @(negedge clk);
    req_log.delete(); gen_idx = 0;
    num_pass = 0; timeout = 0; start = 1'b1;
    sc = cyc;
    @(negedge clk);
    num_pass = 3;
    check("zero/busy_t1", busy, 1);
    check("zero/done_t1", done, 0);
    @(negedge clk);
    start = 1'b0;
    check("zero/done_t2", done, 1);
    check("zero/busy_t2", busy, 0);
    check("zero/cycle_t2", cyc, sc + 2);
    repeat (10) @(negedge clk);
    check("zero/no_req", req_log.size(), 0);
    check("zero/pass_cnt", pass_cnt, 0);

    // Reset while waiting on the second pass.
    set_gen(2, 'b1);
    gen_lat[1] = 0;
    @(negedge clk);
    req_log.delete(); gen_idx = 0;
    num_pass = 3; timeout = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (req_log.size() < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("pre_rst/pass_cnt", pass_cnt, 1);
    check("pre_rst/first_fail", first_fail, 0);
    check("pre_rst/busy", busy, 1);
    xrst = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    @(negedge clk);
    xrst = 1'b1;
    check("mid_rst/no_done", done, 0);
    set_gen(2, 0);
    run(1, 0, "post_rst", 1, 0, NO_FAIL, 0);

    // Randomised runs against the timing model.
    for (int r = 0; r < 25; r++) begin
      int n, t;
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      t = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 12));
      for (int i = 0; i < 16; i++) begin
        gen_lat[i]  = $urandom_range(1, 10);
        gen_errv[i] = ($urandom_range(0, 3) == 0);
      end
      model(n, t, 0);
      run(n, t, $sformatf("rnd%0d", r), m_pass, m_err, m_ff, m_to);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
